// File: rtl/usb_cmd_pkg.sv
// Shared types and constants for the USB command decoder: FSM states,
// three-byte packet tokens, packet lengths and the response byte selector.
package usb_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC_0,
    S_SYNC_1,
    S_SYNC_2,
    S_ID,
    S_ARG,
    S_DISPATCH,
    S_WAIT_RESP,
    S_RESP
  } state_t;

  localparam logic [23:0] TOK_CMD = 24'h434D44;
  localparam logic [23:0] TOK_CMP = 24'h434D50;
  localparam logic [23:0] TOK_ERR = 24'h455252;

  localparam int REQ_LEN   = 12;
  localparam int RESP_LEN  = 8;
  localparam int ARG_BYTES = REQ_LEN - 4;

  // Byte idx of the response packet: token, echoed id, data big-endian.
  function automatic logic [7:0] resp_byte(input logic        err,
                                           input logic [7:0]  id,
                                           input logic [31:0] data,
                                           input logic [2:0]  idx);
    logic [63:0] pkt;
    pkt = {(err ? TOK_ERR : TOK_CMP), id, data};
    pkt = pkt << {idx, 3'b000};
    return pkt[63:56];
  endfunction

endpackage

// File: rtl/if_system.sv
// System clock/reset bundle shared by the USB-side blocks.
interface if_system;
  logic clk;
  logic reset;

  modport sys (input clk, input reset);
endinterface

// File: rtl/usb_cmd_decoder.sv
// Decodes "CMD" request packets from the USB receive FIFO into a command
// handshake and serialises the consumer's response back as "CMP"/"ERR".
module usb_cmd_decoder
  import usb_cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
  if_system.sys       sys,
  input  logic        rx_empty,
  output logic        rx_read,
  input  logic [7:0]  rx_rdata,
  input  logic        tx_full,
  output logic        tx_write,
  output logic [7:0]  tx_wdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_id,
  output logic [31:0] cmd_arg0,
  output logic [31:0] cmd_arg1,
  input  logic        resp_valid,
  input  logic        resp_error,
  input  logic [31:0] resp_data,
  output logic        resp_ready,
  output logic        timeout_event
);

  state_t      state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [2:0]  arg_cnt_q, arg_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  id_q, id_d;
  logic [31:0] arg0_q, arg0_d;
  logic [31:0] arg1_q, arg1_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        tmo_evt_q, tmo_evt_d;

  logic in_rx_state, in_pkt, tmo_hit, capture;

  // A mismatching sync byte that is itself a 'C' may start a new token.
  function automatic state_t resync(input logic [7:0] b);
    return (b == TOK_CMD[23:16]) ? S_SYNC_1 : S_SYNC_0;
  endfunction

  always_comb begin
    in_rx_state = state_q inside {S_SYNC_0, S_SYNC_1, S_SYNC_2, S_ID, S_ARG};
    in_pkt      = state_q inside {S_SYNC_1, S_SYNC_2, S_ID, S_ARG};
    tmo_hit     = in_pkt && (tmo_cnt_q >= TIMEOUT_CYCLES - 24'd1);
    // A byte landing on the timeout cycle belongs to the abandoned packet.
    capture     = rd_pend_q && !tmo_hit;

    rx_read    = !sys.reset && in_rx_state && !rx_empty && !rd_pend_q && !tmo_hit;
    tx_write   = !sys.reset && (state_q == S_RESP) && !tx_full;
    tx_wdata   = (state_q == S_RESP) ? resp_byte(resp_err_q, id_q, resp_data_q, tx_idx_q)
                                     : 8'h00;
    cmd_valid  = (state_q == S_DISPATCH);
    resp_ready = (state_q == S_WAIT_RESP);
    cmd_id     = id_q;
    cmd_arg0   = arg0_q;
    cmd_arg1   = arg1_q;
    timeout_event = tmo_evt_q;
  end

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rx_read;
    arg_cnt_d   = arg_cnt_q;
    tx_idx_d    = tx_idx_q;
    tmo_cnt_d   = in_pkt ? tmo_cnt_q + 24'd1 : 24'd0;
    id_d        = id_q;
    arg0_d      = arg0_q;
    arg1_d      = arg1_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    tmo_evt_d   = tmo_hit;

    if (capture) tmo_cnt_d = 24'd0;

    case (state_q)
      S_SYNC_0: if (capture && rx_rdata == TOK_CMD[23:16]) state_d = S_SYNC_1;
      S_SYNC_1: if (capture) state_d = (rx_rdata == TOK_CMD[15:8]) ? S_SYNC_2 : resync(rx_rdata);
      S_SYNC_2: if (capture) state_d = (rx_rdata == TOK_CMD[7:0])  ? S_ID     : resync(rx_rdata);
      S_ID: begin
        if (capture) begin
          id_d      = rx_rdata;
          arg_cnt_d = 3'd0;
          state_d   = S_ARG;
        end
      end
      S_ARG: begin
        if (capture) begin
          {arg0_d, arg1_d} = {arg0_q[23:0], arg1_q, rx_rdata};
          arg_cnt_d        = arg_cnt_q + 3'd1;
          if (arg_cnt_q == 3'(ARG_BYTES - 1)) state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: if (cmd_ready) state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (resp_valid) begin
          resp_err_d  = resp_error;
          resp_data_d = resp_data;
          tx_idx_d    = 3'd0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_write) begin
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'(RESP_LEN - 1)) state_d = S_SYNC_0;
        end
      end
      default: state_d = S_SYNC_0;
    endcase

    if (tmo_hit) begin
      state_d   = S_SYNC_0;
      tmo_cnt_d = 24'd0;
    end
  end

  always_ff @(posedge sys.clk) begin
    if (sys.reset) begin
      state_q     <= S_SYNC_0;
      rd_pend_q   <= 1'b0;
      arg_cnt_q   <= 3'd0;
      tx_idx_q    <= 3'd0;
      tmo_cnt_q   <= 24'd0;
      id_q        <= 8'h00;
      arg0_q      <= 32'h0;
      arg1_q      <= 32'h0;
      resp_err_q  <= 1'b0;
      resp_data_q <= 32'h0;
      tmo_evt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      arg_cnt_q   <= arg_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      id_q        <= id_d;
      arg0_q      <= arg0_d;
      arg1_q      <= arg1_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      tmo_evt_q   <= tmo_evt_d;
    end
  end

endmodule
